// File: rtl/implication_queue_if.sv
// Handshake bundle between the unit-clause evaluators / BCP controller and the
// implication queue: push side, pop side, flush and conflict report.
interface implication_queue_if #(
   parameter int VARIABLE_INDEX = 6,
   parameter int PTR_W          = 4
);
   logic                    push_valid;
   logic [VARIABLE_INDEX:0] push_variable;
   logic                    push_val;
   logic                    push_ready;
   logic                    pop_valid;
   logic [VARIABLE_INDEX:0] pop_variable;
   logic                    pop_val;
   logic                    pop_ready;
   logic                    clear;
   logic                    conflict;
   logic [VARIABLE_INDEX:0] conflict_variable;
   logic [PTR_W:0]          count;

   modport master (
      output push_valid, push_variable, push_val, pop_ready, clear,
      input  push_ready, pop_valid, pop_variable, pop_val,
             conflict, conflict_variable, count
   );

   modport slave (
      input  push_valid, push_variable, push_val, pop_ready, clear,
      output push_ready, pop_valid, pop_variable, pop_val,
             conflict, conflict_variable, count
   );
endinterface

// File: rtl/implication_queue.sv
// In-order FIFO of unit-clause implications with per-variable in-flight tracking
// that drops duplicates and flags contradictory implications as a sticky conflict.
module implication_queue #(
   parameter int NUM_VARIABLE   = 128,
   parameter int VARIABLE_INDEX = 6,
   parameter int DEPTH          = 16,
   parameter int PTR_W          = 4
) (
   input logic               clock,
   input logic               reset,
   implication_queue_if.slave q
);

   typedef struct packed {
      logic [VARIABLE_INDEX:0] variable;
      logic                    val;
   } entry_t;

   entry_t                  mem [DEPTH];
   logic [PTR_W-1:0]        head, tail;
   logic [PTR_W:0]          count;
   logic [NUM_VARIABLE-1:0] pending, pending_val;
   logic                    conflict;
   logic [VARIABLE_INDEX:0] conflict_variable;

   logic   push_fire, pop_fire, is_pending, enq, contra, empty;
   entry_t head_entry;

   assign empty      = (count == '0);
   assign q.push_ready = (count != (PTR_W+1)'(DEPTH)) && !conflict;
   assign q.pop_valid  = !empty && !conflict;
   assign push_fire  = q.push_valid && q.push_ready;
   assign pop_fire   = q.pop_valid && q.pop_ready;

   // Classification uses pending as registered, so a push racing the pop of the
   // same variable still sees it in flight.
   assign is_pending = pending[q.push_variable];
   assign enq        = push_fire && !is_pending;
   assign contra     = push_fire && is_pending && (pending_val[q.push_variable] != q.push_val);

   assign head_entry     = mem[head];
   assign q.pop_variable = empty ? '0 : head_entry.variable;
   assign q.pop_val      = empty ? 1'b0 : head_entry.val;
   assign q.count             = count;
   assign q.conflict          = conflict;
   assign q.conflict_variable = conflict_variable;

   always_ff @(posedge clock) begin
      if (enq && !q.clear) mem[tail] <= '{variable: q.push_variable, val: q.push_val};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         pending           <= '0;
         pending_val       <= '0;
         conflict          <= 1'b0;
         conflict_variable <= '0;
      end else if (q.clear) begin
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         pending           <= '0;
         pending_val       <= '0;
         conflict          <= 1'b0;
         conflict_variable <= '0;
      end else begin
         if (enq) begin
            tail                          <= tail + 1'b1;
            pending[q.push_variable]      <= 1'b1;
            pending_val[q.push_variable]  <= q.push_val;
         end
         if (pop_fire) begin
            head                           <= head + 1'b1;
            pending[head_entry.variable]   <= 1'b0;
         end
         if (contra) begin
            conflict          <= 1'b1;
            conflict_variable <= q.push_variable;
         end
         case ({enq, pop_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_implication_queue.sv
// Directed bench: stimulus pushes expected pops onto a scoreboard queue, a
// negedge monitor compares every completed pop; status checks run inline.
module tb_implication_queue;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   typedef struct packed {
      logic [6:0] variable;
      logic       val;
   } exp_t;
   exp_t exp_q[$];

   implication_queue_if #(.VARIABLE_INDEX(6), .PTR_W(4)) qif ();

   implication_queue dut (.clock(clock), .reset(reset), .q(qif));

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   // Inputs change at posedge+1 and are consumed by the following posedge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int v, input bit val, input bit expect_enq);
      qif.push_valid    = 1'b1;
      qif.push_variable = 7'(v);
      qif.push_val      = val;
      if (expect_enq) exp_q.push_back('{variable: 7'(v), val: val});
      tick();
      qif.push_valid = 1'b0;
   endtask

   task automatic pop_n(input int n);
      qif.pop_ready = 1'b1;
      repeat (n) tick();
      qif.pop_ready = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clock) begin
      if (!reset && qif.pop_valid && qif.pop_ready && !qif.clear) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected got=%0d/%0d exp=none", qif.pop_variable, qif.pop_val);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (qif.pop_variable != e.variable || qif.pop_val != e.val) begin
               bad++;
               $display("FAIL pop_data got=%0d/%0d exp=%0d/%0d",
                        qif.pop_variable, qif.pop_val, e.variable, e.val);
            end
         end
      end
   end

   initial begin
      qif.push_valid = 1'b0; qif.push_variable = '0; qif.push_val = 1'b0;
      qif.pop_ready = 1'b0;  qif.clear = 1'b0;
      #12;
      chk("rst_count", qif.count, 0);
      chk("rst_push_ready", qif.push_ready, 1);
      chk("rst_pop_valid", qif.pop_valid, 0);
      chk("rst_pop_variable", qif.pop_variable, 0);
      chk("rst_conflict", qif.conflict, 0);
      reset = 1'b0;
      tick();

      // 1: mid-run async reset
      push(3, 1, 1); push(4, 0, 1); push(6, 1, 1);
      chk("t1_count_pre", qif.count, 3);
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("t1_count", qif.count, 0);
      chk("t1_pop_valid", qif.pop_valid, 0);
      chk("t1_conflict", qif.conflict, 0);
      chk("t1_push_ready", qif.push_ready, 1);
      reset = 1'b0;
      tick();

      // 2: in-order delivery
      push(5, 1, 1); push(9, 0, 1); push(42, 1, 1);
      chk("t2_count", qif.count, 3);
      chk("t2_head", qif.pop_variable, 5);
      pop_n(3);
      chk("t2_count_end", qif.count, 0);
      chk("t2_pop_valid_end", qif.pop_valid, 0);
      chk("t2_pop_var_end", qif.pop_variable, 0);

      // 3: duplicate then contradiction
      push(17, 1, 1); push(17, 1, 0);
      chk("t3_dup_count", qif.count, 1);
      push(17, 0, 0);
      chk("t3_conflict", qif.conflict, 1);
      chk("t3_conflict_var", qif.conflict_variable, 17);
      chk("t3_push_ready", qif.push_ready, 0);
      chk("t3_pop_valid", qif.pop_valid, 0);
      qif.clear = 1'b1; exp_q.delete(); tick(); qif.clear = 1'b0;
      chk("t3_clr_conflict", qif.conflict, 0);
      chk("t3_clr_count", qif.count, 0);
      chk("t3_clr_cvar", qif.conflict_variable, 0);

      // 4: fill, hold-off, wrap
      for (int i = 0; i < 16; i++) push(i, i[0], 1);
      chk("t4_full_count", qif.count, 16);
      chk("t4_full_ready", qif.push_ready, 0);
      qif.push_valid = 1'b1; qif.push_variable = 7'd20; qif.push_val = 1'b1;
      tick();
      chk("t4_held_count", qif.count, 16);
      qif.pop_ready = 1'b1; tick(); qif.pop_ready = 1'b0;
      chk("t4_after_pop_count", qif.count, 15);
      chk("t4_after_pop_ready", qif.push_ready, 1);
      exp_q.push_back('{variable: 7'd20, val: 1'b1});
      tick();
      qif.push_valid = 1'b0;
      chk("t4_refill_count", qif.count, 16);
      pop_n(16);
      chk("t4_drain_count", qif.count, 0);

      // 5: push contradicting the head while it pops
      push(30, 1, 1);
      qif.push_valid = 1'b1; qif.push_variable = 7'd30; qif.push_val = 1'b0;
      qif.pop_ready = 1'b1;
      tick();
      qif.push_valid = 1'b0; qif.pop_ready = 1'b0;
      chk("t5_conflict", qif.conflict, 1);
      chk("t5_conflict_var", qif.conflict_variable, 30);
      chk("t5_count", qif.count, 0);
      qif.clear = 1'b1; exp_q.delete(); tick(); qif.clear = 1'b0;

      // 6: clear wins over push and pop
      push(50, 1, 1);
      qif.clear = 1'b1;
      qif.push_valid = 1'b1; qif.push_variable = 7'd51; qif.push_val = 1'b0;
      qif.pop_ready = 1'b1;
      exp_q.delete();
      tick();
      qif.clear = 1'b0; qif.push_valid = 1'b0; qif.pop_ready = 1'b0;
      chk("t6_count", qif.count, 0);
      chk("t6_pop_valid", qif.pop_valid, 0);
      push(51, 1, 1);
      push(50, 0, 1);
      chk("t6_requeue_count", qif.count, 2);
      chk("t6_no_conflict", qif.conflict, 0);
      pop_n(2);
      chk("t6_drain_count", qif.count, 0);

      chk("sb_leftover", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
